// File: rtl/pl_imem_loader.sv
// Boot loader: parses a framed byte stream (MAGIC, 16-bit word count, big-endian words, XOR checksum)
// into instruction-memory writes, holding the CPU in reset until a verified image is in place.
module pl_imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int WIDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                hold_q, hold_d;

    logic        accept;
    logic [15:0] cnt_rx;

    assign rx_ready = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept   = rx_valid && rx_ready;
    assign cnt_rx   = {cnt_q[15:8], rx_data};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (start) begin
            // Abort wins over a byte presented in the same cycle; that byte is dropped.
            state_d = S_IDLE;
        end else if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == MAGIC) begin
                        state_d = S_CNT_HI;
                        csum_d  = '0;
                        widx_d  = '0;
                        bidx_d  = '0;
                    end
                end
                S_CNT_HI: begin
                    cnt_d   = {rx_data, cnt_q[7:0]};
                    state_d = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_d = cnt_rx;
                    if (32'(cnt_rx) > DEPTH)  state_d = S_ERR;
                    else if (cnt_rx == '0)    state_d = S_CSUM;
                    else                      state_d = S_DATA;
                end
                S_DATA: begin
                    asm_d  = {asm_q[15:0], rx_data};
                    csum_d = csum_q ^ rx_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {asm_q, rx_data};
                        addr_d  = BASE_ADDR + (32'(widx_q) << 2);
                        widx_d  = widx_q + WIDX_W'(1);
                        if (32'(widx_q) + 32'd1 == 32'(cnt_q)) state_d = S_CSUM;
                    end
                end
                S_CSUM:  state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                default: ;
            endcase
        end

        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        hold_d  = (state_d != S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = hold_q;

endmodule
